// File: rtl/ppu_oam_regs_if.sv
// CPU/DMA register bus plus sprite-evaluation read port for the OAM block.
// The master drives requests and the slave (ppu_oam_regs) returns registered read data.
interface ppu_oam_regs_if;
  logic        i_bus_cs;
  logic [15:0] i_bus_addr;
  logic        i_bus_wn;
  logic [7:0]  i_bus_wdata;
  logic [7:0]  o_bus_rdata;
  logic        o_bus_rvld;
  logic        i_ev_rd;
  logic [7:0]  i_ev_addr;
  logic [7:0]  o_ev_rdata;
  logic        o_ev_vld;

  modport master (
    output i_bus_cs, i_bus_addr, i_bus_wn, i_bus_wdata, i_ev_rd, i_ev_addr,
    input  o_bus_rdata, o_bus_rvld, o_ev_rdata, o_ev_vld
  );

  modport slave (
    input  i_bus_cs, i_bus_addr, i_bus_wn, i_bus_wdata, i_ev_rd, i_ev_addr,
    output o_bus_rdata, o_bus_rvld, o_ev_rdata, o_ev_vld
  );
endinterface

// File: rtl/ppu_oam_regs.sv
// OAMADDR/OAMDATA register decode and the 256x8 sprite attribute RAM.
// Reads return one cycle later; no backpressure, colliding bus writes are dropped.
module ppu_oam_regs (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_render,
  input  logic          i_oamaddr_clr,
  ppu_oam_regs_if.slave bus
);

  logic [7:0] oam [256];
  logic [7:0] oamaddr;

  logic       reg_hit;
  logic       oamaddr_wr;
  logic       oamdata_wr;
  logic       oamdata_rd;
  logic       ram_wr;
  logic [7:0] rd_addr;
  logic [7:0] rd_byte;
  logic       unused_addr_bits;

  // PPU registers are mirrored every 8 bytes across $2000-$3FFF.
  assign reg_hit    = bus.i_bus_cs && (bus.i_bus_addr[15:13] == 3'b001);
  assign oamaddr_wr = reg_hit && (bus.i_bus_addr[2:0] == 3'd3) && !bus.i_bus_wn;
  assign oamdata_wr = reg_hit && (bus.i_bus_addr[2:0] == 3'd4) && !bus.i_bus_wn;
  assign oamdata_rd = reg_hit && (bus.i_bus_addr[2:0] == 3'd4) &&  bus.i_bus_wn;

  // Evaluation owns the single RAM port; a bus write in the same cycle is lost.
  assign ram_wr  = oamdata_wr && !i_render && !bus.i_ev_rd;
  assign rd_addr = bus.i_ev_rd ? bus.i_ev_addr : oamaddr;

  // Attribute bytes have no storage behind bits 4:2.
  assign rd_byte = (rd_addr[1:0] == 2'd2) ? (oam[rd_addr] & 8'hE3) : oam[rd_addr];

  assign unused_addr_bits = ^bus.i_bus_addr[12:3];

  always_ff @(posedge i_clk) begin
    if (ram_wr) begin
      oam[oamaddr] <= bus.i_bus_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      oamaddr         <= 8'h00;
      bus.o_bus_rdata <= 8'h00;
      bus.o_bus_rvld  <= 1'b0;
      bus.o_ev_rdata  <= 8'h00;
      bus.o_ev_vld    <= 1'b0;
    end else begin
      bus.o_bus_rvld <= oamdata_rd;
      bus.o_ev_vld   <= bus.i_ev_rd;
      if (oamdata_rd) begin
        bus.o_bus_rdata <= rd_byte;
      end
      if (bus.i_ev_rd) begin
        bus.o_ev_rdata <= rd_byte;
      end
      if (i_oamaddr_clr) begin
        oamaddr <= 8'h00;
      end else if (oamaddr_wr) begin
        oamaddr <= bus.i_bus_wdata;
      end else if (ram_wr) begin
        oamaddr <= oamaddr + 8'd1;
      end
    end
  end

endmodule
